// File: rtl/tick_feeder.sv
// Tick FIFO feeding the moment engine's sample stream, with zero-sample flush.
// Optional TICK_FEEDER_DROP_CNT_EN adds a saturating refused-write counter.
module tick_feeder #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int WINDOW = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_valid,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     wr_ready,
   input  logic                     start,
   input  logic                     flush,
   output logic                     tx_valid,
   output logic [WIDTH-1:0]         tx_data,
   input  logic                     tx_ready,
   output logic                     win_primed,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy
`ifdef TICK_FEEDER_DROP_CNT_EN
   ,
   output logic [15:0]              drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = $clog2(WINDOW + 1);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      FLUSH
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    prime_q, prime_d;
   logic [PW-1:0]    fcnt_q, fcnt_d;

   logic full, empty, wr_en, pop, enter_flush;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign wr_ready = !full;
   assign wr_en    = wr_valid && !full;
   assign pop      = (state_q == STREAM) && !empty && tx_ready;

   assign count      = count_q;
   assign busy       = (state_q != IDLE);
   assign win_primed = (prime_q == PW'(WINDOW));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (flush)      state_d = FLUSH;
            else if (start) state_d = STREAM;
         end
         STREAM: begin
            if (flush) state_d = FLUSH;
         end
         FLUSH: begin
            if (tx_ready && fcnt_q == PW'(WINDOW - 1))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign enter_flush = (state_q != FLUSH) && (state_d == FLUSH);

   always_comb begin
      tx_valid = 1'b0;
      tx_data  = '0;
      unique case (state_q)
         STREAM: begin
            tx_valid = !empty;
            tx_data  = empty ? '0 : mem_q[rd_ptr_q];
         end
         FLUSH: begin
            tx_valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      prime_d  = prime_q;
      fcnt_d   = fcnt_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: ;
      endcase
      // Entry into FLUSH wins over a same-cycle final STREAM handshake.
      if (enter_flush) begin
         prime_d = '0;
         fcnt_d  = '0;
      end else begin
         if (pop && prime_q != PW'(WINDOW))
            prime_d = prime_q + 1'b1;
         if (state_q == FLUSH && tx_ready)
            fcnt_d = fcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         prime_q  <= '0;
         fcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         prime_q  <= prime_d;
         fcnt_q   <= fcnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data;
   end

`ifdef TICK_FEEDER_DROP_CNT_EN
   logic [15:0] drop_q, drop_d;

   always_comb begin
      drop_d = drop_q;
      if (wr_valid && !wr_ready && drop_q != 16'hFFFF)
         drop_d = drop_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) drop_q <= '0;
      else      drop_q <= drop_d;
   end

   assign drop_cnt = drop_q;
`endif

endmodule
